// File: rtl/flood_pkg.sv
// flood_pkg: shared constants, FSM state encoding and cell type for the flood fill engine
package flood_pkg;
  localparam int MAX_SIZE = 26;
  localparam int COLOR_W = 3;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {IDLE, REQ, LOAD, GROW, WAIT_MOVE, RECOLOR, WON} state_t;
  typedef logic [COLOR_W-1:0] cell_t;
endpackage

// File: rtl/flood_grow_scan.sv
// flood_grow_scan: raster walk of the active board with neighbour-mask join test and pass flags
module flood_grow_scan
  import flood_pkg::*;
(
  input  logic CLOCK,
  input  logic RESET,
  input  logic start,
  input  logic en,
  input  logic [4:0] size,
  input  logic [MAX_SIZE-1:0][MAX_SIZE-1:0] mask,
  input  logic match,
  output logic [4:0] row,
  output logic [4:0] col,
  output logic join_cell,
  output logic pass_end,
  output logic again
);
  logic changed, last_col, last_row, nb;
  always_comb begin
    last_col = col == size - 5'd1;
    last_row = row == size - 5'd1;
    nb = (row != 5'd0 && mask[row - 5'd1][col]) || (!last_row && mask[row + 5'd1][col]) ||
         (col != 5'd0 && mask[row][col - 5'd1]) || (!last_col && mask[row][col + 5'd1]);
    join_cell = en && !mask[row][col] && match && nb;
    pass_end = en && last_row && last_col;
    again = changed || join_cell;
  end
  always_ff @(posedge CLOCK)
    if (RESET || start) begin
      row <= '0;
      col <= '0;
      changed <= 1'b0;
    end else if (en) begin
      col <= last_col ? 5'd0 : col + 5'd1;
      row <= last_col ? (last_row ? 5'd0 : row + 5'd1) : row;
      changed <= pass_end ? 1'b0 : again;
    end
endmodule

// File: rtl/flood_fill_engine.sv
// flood_fill_engine: loads a generated board, recolours and grows the (0,0) flood region per move
module flood_fill_engine
  import flood_pkg::*;
(
  input  logic CLOCK,
  input  logic RESET,
  input  logic START_GAME,
  input  logic [4:0] final_SIZE,
  input  logic [3:0] final_COLOR_NUM,
  output logic INITIALIZE_BOARD,
  input  logic BOARD_READY,
  input  logic [MAX_SIZE-1:0][MAX_SIZE-1:0][COLOR_W-1:0] INITIAL_BOARD,
  input  logic MOVE_VALID,
  input  logic [COLOR_W-1:0] MOVE_COLOR,
  output logic MOVE_READY,
  output logic [MAX_SIZE-1:0][MAX_SIZE-1:0][COLOR_W-1:0] BOARD,
  output logic [COLOR_W-1:0] REGION_COLOR,
  output logic [CNT_W-1:0] MOVE_COUNT,
  output logic BUSY,
  output logic GAME_WON
);
  state_t state, state_nx;
  logic [4:0] size_q, row, col;
  logic [3:0] ncol_q;
  logic [MAX_SIZE-1:0][MAX_SIZE-1:0] mask;
  logic [9:0] count;
  cell_t color_q;
  logic take_start, take_move, move_ok, join_cell, pass_end, again;
  flood_grow_scan u_scan (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .start(state == LOAD || state == RECOLOR),
    .en(state == GROW),
    .size(size_q),
    .mask(mask),
    .match(BOARD[row][col] == REGION_COLOR),
    .row(row),
    .col(col),
    .join_cell(join_cell),
    .pass_end(pass_end),
    .again(again)
  );
  always_ff @(posedge CLOCK)
    state <= RESET ? IDLE : state_nx;
  always_comb begin
    take_start = START_GAME && (state == IDLE || state == WAIT_MOVE || state == WON);
    move_ok = {1'b0, MOVE_COLOR} < ncol_q && MOVE_COLOR != REGION_COLOR;
    take_move = MOVE_VALID && MOVE_READY && move_ok;
    state_nx = state;
    case (state)
      REQ: state_nx = BOARD_READY ? LOAD : REQ;
      LOAD: state_nx = GROW;
      GROW: state_nx = pass_end && !again ? (count == {5'd0, size_q} * {5'd0, size_q} ? WON : WAIT_MOVE) : GROW;
      WAIT_MOVE: state_nx = take_move ? RECOLOR : WAIT_MOVE;
      RECOLOR: state_nx = GROW;
      default: state_nx = state;
    endcase
    state_nx = take_start ? REQ : state_nx;
  end
  always_comb begin
    MOVE_READY = state == WAIT_MOVE;
    GAME_WON = state == WON;
    BUSY = state != IDLE && state != WAIT_MOVE;
    REGION_COLOR = BOARD[0][0];
  end
  always_ff @(posedge CLOCK)
    if (RESET) begin
      size_q <= '0;
      ncol_q <= '0;
      INITIALIZE_BOARD <= 1'b0;
      BOARD <= '0;
      mask <= '0;
      count <= '0;
      MOVE_COUNT <= '0;
      color_q <= '0;
    end else begin
      if (take_start) begin
        size_q <= final_SIZE;
        ncol_q <= final_COLOR_NUM;
        MOVE_COUNT <= '0;
        INITIALIZE_BOARD <= 1'b1;
      end
      if (state == LOAD) begin
        INITIALIZE_BOARD <= 1'b0;
        BOARD <= INITIAL_BOARD;
        mask <= '0;
        mask[0][0] <= 1'b1;
        count <= 10'd1;
      end
      if (join_cell) begin
        mask[row][col] <= 1'b1;
        count <= count + 10'd1;
      end
      if (take_move) begin
        color_q <= MOVE_COLOR;
        MOVE_COUNT <= MOVE_COUNT == '1 ? MOVE_COUNT : MOVE_COUNT + CNT_W'(1);
      end
      if (state == RECOLOR)
        for (int r = 0; r < MAX_SIZE; r++)
          for (int c = 0; c < MAX_SIZE; c++)
            if (mask[r][c])
              BOARD[r][c] <= color_q;
    end
endmodule
